// File: rtl/bridge_slave_port_arbiter.sv
// Purpose : per-slave-port scheduler; CH0 (core) requesters have priority over CH1 (DMA),
//           CH1 gets starvation-bounded access, round-robin within each channel.
// Latency : arbitration is combinational (0 cycles); pointers/state/counters update on clk.
// Backpr. : data_req_o masked while outstanding == MAX_OUT; slave stall (data_gnt_i=0) holds pointers.
// Ports   : data_*_i     requester side (N packed lanes), data_gnt_o one-hot grant
//           data_*_o     muxed winner payload to slave, data_ID_o one-hot winner ID
//           data_r_*     response valid routed back by one-hot ID
//           outstanding_o in-flight count, err_o sticky protocol error
module bridge_slave_port_arbiter #(
  parameter int N_CH0        = 5,
  parameter int N_CH1        = 4,
  parameter int ID_WIDTH     = N_CH0 + N_CH1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_WIDTH    = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_OUT      = 4,
  localparam int N           = N_CH0 + N_CH1,
  localparam int BE_WIDTH    = DATA_WIDTH / 8,
  localparam int OW          = $clog2(MAX_OUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               data_req_i,
  input  logic [N*ADDR_WIDTH-1:0]    data_add_i,
  input  logic [N-1:0]               data_wen_i,
  input  logic [N*DATA_WIDTH-1:0]    data_wdata_i,
  input  logic [N*BE_WIDTH-1:0]      data_be_i,
  input  logic [N*AUX_WIDTH-1:0]     data_aux_i,
  output logic [N-1:0]               data_gnt_o,
  output logic                       data_req_o,
  output logic [ADDR_WIDTH-1:0]      data_add_o,
  output logic                       data_wen_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  output logic [BE_WIDTH-1:0]        data_be_o,
  output logic [AUX_WIDTH-1:0]       data_aux_o,
  output logic [ID_WIDTH-1:0]        data_ID_o,
  input  logic                       data_gnt_i,
  input  logic                       data_r_valid_i,
  input  logic [ID_WIDTH-1:0]        data_r_ID_i,
  output logic [N-1:0]               data_r_valid_o,
  output logic [OW-1:0]              outstanding_o,
  output logic                       err_o
);

  // C1 keeps vector widths legal when the CH1 channel is absent.
  localparam int C1  = (N_CH1 > 0) ? N_CH1 : 1;
  localparam int P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
  localparam int P1W = (C1 > 1) ? $clog2(C1) : 1;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_CH0_PRIO = 1'b0;
  localparam logic [0:0] ST_CH1_PRIO = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [P0W-1:0] ptr0_q, ptr0_d;
  logic [P1W-1:0] ptr1_q, ptr1_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [OW-1:0]  out_q, out_d;
  logic           err_q, err_d;

  logic [N_CH0-1:0] ch0_req;
  logic [C1-1:0]    ch1_req;
  logic             pick0_vld, pick1_vld;
  logic [P0W-1:0]   pick0_loc;
  logic [P1W-1:0]   pick1_loc;
  logic             win_vld, win_ch1;
  logic [N-1:0]     win_oh;
  logic             full, accept, ch1_pend, ch1_acc;

  assign ch0_req = data_req_i[N_CH0-1:0];

  if (N_CH1 > 0) begin : g_ch1
    assign ch1_req = data_req_i[N-1:N_CH0];
  end else begin : g_no_ch1
    assign ch1_req = '0;
  end

  // Round-robin pick: first pass looks at indices >= pointer, second pass wraps to the bottom.
  always_comb begin
    pick0_vld = 1'b0;
    pick0_loc = '0;
    for (int i = 0; i < N_CH0; i++) begin
      if (!pick0_vld && ch0_req[i] && (i >= int'(ptr0_q))) begin
        pick0_vld = 1'b1;
        pick0_loc = P0W'(i);
      end
    end
    for (int i = 0; i < N_CH0; i++) begin
      if (!pick0_vld && ch0_req[i]) begin
        pick0_vld = 1'b1;
        pick0_loc = P0W'(i);
      end
    end
    pick1_vld = 1'b0;
    pick1_loc = '0;
    for (int i = 0; i < C1; i++) begin
      if (!pick1_vld && ch1_req[i] && (i >= int'(ptr1_q))) begin
        pick1_vld = 1'b1;
        pick1_loc = P1W'(i);
      end
    end
    for (int i = 0; i < C1; i++) begin
      if (!pick1_vld && ch1_req[i]) begin
        pick1_vld = 1'b1;
        pick1_loc = P1W'(i);
      end
    end
  end

  // Channel priority follows the state; the other channel is the fallback.
  always_comb begin
    win_vld = 1'b0;
    win_ch1 = 1'b0;
    if (state_q == ST_CH1_PRIO && pick1_vld) begin
      win_vld = 1'b1;
      win_ch1 = 1'b1;
    end else if (pick0_vld) begin
      win_vld = 1'b1;
    end else if (pick1_vld) begin
      win_vld = 1'b1;
      win_ch1 = 1'b1;
    end
    win_oh = '0;
    for (int i = 0; i < N_CH0; i++)
      win_oh[i] = win_vld && !win_ch1 && (pick0_loc == P0W'(i));
    for (int i = 0; i < N_CH1; i++)
      win_oh[N_CH0+i] = win_vld && win_ch1 && (pick1_loc == P1W'(i));
  end

  assign full       = (out_q == OW'(MAX_OUT));
  assign data_req_o = !rst && win_vld && !full;
  assign accept     = data_req_o && data_gnt_i;
  assign data_gnt_o = accept ? win_oh : '0;
  assign ch1_pend   = |ch1_req;
  assign ch1_acc    = accept && win_ch1;

  // Payload mux driven by the one-hot winner.
  always_comb begin
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    data_aux_o   = '0;
    data_ID_o    = '0;
    for (int i = 0; i < N; i++) begin
      data_ID_o[i] = win_oh[i];
      if (win_oh[i]) begin
        data_add_o   = data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_wen_o   = data_wen_i[i];
        data_wdata_o = data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        data_be_o    = data_be_i[i*BE_WIDTH +: BE_WIDTH];
        data_aux_o   = data_aux_i[i*AUX_WIDTH +: AUX_WIDTH];
      end
    end
  end

  always_comb begin
    data_r_valid_o = '0;
    for (int i = 0; i < N; i++)
      data_r_valid_o[i] = !rst && data_r_valid_i && data_r_ID_i[i];
  end

  always_comb begin
    ptr0_d = ptr0_q;
    ptr1_d = ptr1_q;
    if (accept && !win_ch1)
      ptr0_d = (pick0_loc == P0W'(N_CH0 - 1)) ? '0 : pick0_loc + P0W'(1);
    if (accept && win_ch1)
      ptr1_d = (pick1_loc == P1W'(C1 - 1)) ? '0 : pick1_loc + P1W'(1);

    // Counts CH1 waiting cycles; saturates so CH1_PRIO stays asserted while blocked (e.g. full).
    if (ch1_pend && !ch1_acc)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    else
      starve_d = '0;

    // Switch to CH1 priority the cycle after the wait count reaches the limit.
    state_d = state_q;
    case (state_q)
      ST_CH0_PRIO: if (starve_d == SW'(STARVE_LIMIT)) state_d = ST_CH1_PRIO;
      default:     if (ch1_acc || !ch1_pend)          state_d = ST_CH0_PRIO;
    endcase

    out_d = out_q;
    case ({accept, data_r_valid_i})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = (out_q == '0) ? out_q : out_q - OW'(1);
      default: out_d = out_q;
    endcase

    err_d = err_q | (data_r_valid_i && ((out_q == '0) || !$onehot(data_r_ID_i)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CH0_PRIO;
      ptr0_q   <= '0;
      ptr1_q   <= '0;
      starve_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr0_q   <= ptr0_d;
      ptr1_q   <= ptr1_d;
      starve_q <= starve_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign outstanding_o = out_q;
  assign err_o         = err_q;

endmodule
